// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, logic/shift ALU with same-cycle forwarding outputs,
// and a 32-step restoring divider for DIV/DIVU that writes HI/LO and stalls the front end.
module ex_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_id_stall,
  input  logic        i_ex_stall,
  input  logic [7:0]  i_aluop,
  input  logic [2:0]  i_alusel,
  input  logic [31:0] i_reg1,
  input  logic [31:0] i_reg2,
  input  logic [4:0]  i_wd,
  input  logic        i_wreg,
  output logic [4:0]  o_wd,
  output logic        o_wreg,
  output logic [31:0] o_wdata,
  output logic        o_whilo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_stallreq
);

  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} div_state_t;

  logic [7:0]  r_aluop;
  logic [2:0]  r_alusel;
  logic [31:0] r_reg1;
  logic [31:0] r_reg2;
  logic [4:0]  r_wd;
  logic        r_wreg;

  div_state_t  r_state;
  div_state_t  w_next_state;
  logic [5:0]  r_cnt;
  logic [64:0] r_work;

  logic        w_is_div;
  logic        w_signed;
  logic [31:0] w_op1_mag;
  logic [31:0] w_dvs;
  logic [64:0] w_sh;
  logic [32:0] w_trial;
  logic [64:0] w_step;
  logic [31:0] w_logic;
  logic [31:0] w_shift;

  assign w_is_div  = (r_aluop == OP_DIV) || (r_aluop == OP_DIVU);
  assign w_signed  = (r_aluop == OP_DIV);
  assign w_op1_mag = (w_signed && r_reg1[31]) ? (32'd0 - r_reg1) : r_reg1;
  assign w_dvs     = (w_signed && r_reg2[31]) ? (32'd0 - r_reg2) : r_reg2;

  // One restoring step: shift the partial remainder left, keep the trial difference if no borrow.
  assign w_sh    = {r_work[63:0], 1'b0};
  assign w_trial = w_sh[64:32] - {1'b0, w_dvs};
  assign w_step  = (w_sh[64:32] >= {1'b0, w_dvs}) ? {w_trial, w_sh[31:1], 1'b1} : w_sh;

  // ID/EX pipeline register: reset, hold, bubble, or load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aluop  <= 8'd0;
      r_alusel <= 3'd0;
      r_reg1   <= 32'd0;
      r_reg2   <= 32'd0;
      r_wd     <= 5'd0;
      r_wreg   <= 1'b0;
    end else if (i_ex_stall || o_stallreq) begin
      r_aluop  <= r_aluop;
      r_alusel <= r_alusel;
      r_reg1   <= r_reg1;
      r_reg2   <= r_reg2;
      r_wd     <= r_wd;
      r_wreg   <= r_wreg;
    end else if (i_id_stall) begin
      r_aluop  <= 8'd0;
      r_alusel <= 3'd0;
      r_reg1   <= 32'd0;
      r_reg2   <= 32'd0;
      r_wd     <= 5'd0;
      r_wreg   <= 1'b0;
    end else begin
      r_aluop  <= i_aluop;
      r_alusel <= i_alusel;
      r_reg1   <= i_reg1;
      r_reg2   <= i_reg2;
      r_wd     <= i_wd;
      r_wreg   <= i_wreg;
    end
  end

  // Divider state, step counter and working register {remainder, quotient}.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= DIV_FREE;
      r_cnt   <= 6'd0;
      r_work  <= 65'd0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        DIV_FREE: begin
          if (w_is_div) begin
            r_cnt  <= 6'd0;
            r_work <= {33'd0, w_op1_mag};
          end else begin
            r_cnt  <= r_cnt;
            r_work <= r_work;
          end
        end
        DIV_ON: begin
          r_cnt  <= r_cnt + 6'd1;
          r_work <= w_step;
        end
        DIV_BY_ZERO: begin
          r_cnt  <= r_cnt;
          r_work <= 65'd0;
        end
        default: begin
          r_cnt  <= r_cnt;
          r_work <= r_work;
        end
      endcase
    end
  end

  // Divider next state; DivEnd lingers only while downstream is stalled.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DIV_FREE: begin
        if (w_is_div) begin
          w_next_state = (w_dvs == 32'd0) ? DIV_BY_ZERO : DIV_ON;
        end else begin
          w_next_state = DIV_FREE;
        end
      end
      DIV_ON: begin
        if (r_cnt == 6'd31) begin
          w_next_state = DIV_END;
        end else begin
          w_next_state = DIV_ON;
        end
      end
      DIV_BY_ZERO: w_next_state = DIV_END;
      DIV_END: begin
        if (i_ex_stall) begin
          w_next_state = DIV_END;
        end else begin
          w_next_state = DIV_FREE;
        end
      end
      default: w_next_state = DIV_FREE;
    endcase
  end

  // Logic and shift units.
  always_comb begin
    w_logic = 32'd0;
    w_shift = 32'd0;
    case (r_aluop)
      OP_AND:  w_logic = r_reg1 & r_reg2;
      OP_OR:   w_logic = r_reg1 | r_reg2;
      OP_XOR:  w_logic = r_reg1 ^ r_reg2;
      OP_NOR:  w_logic = ~(r_reg1 | r_reg2);
      default: w_logic = 32'd0;
    endcase
    case (r_aluop)
      OP_SLL:  w_shift = r_reg2 << r_reg1[4:0];
      OP_SRL:  w_shift = r_reg2 >> r_reg1[4:0];
      OP_SRA:  w_shift = $unsigned($signed(r_reg2) >>> r_reg1[4:0]);
      default: w_shift = 32'd0;
    endcase
  end

  // Write-back, forwarding and HI/LO outputs.
  always_comb begin
    o_wdata    = 32'd0;
    o_hi       = 32'd0;
    o_lo       = 32'd0;
    o_whilo    = 1'b0;
    o_wd       = r_wd;
    o_wreg     = w_is_div ? 1'b0 : r_wreg;
    o_stallreq = w_is_div && (r_state != DIV_END);
    case (r_alusel)
      SEL_LOGIC: o_wdata = w_logic;
      SEL_SHIFT: o_wdata = w_shift;
      default:   o_wdata = 32'd0;
    endcase
    if (r_state == DIV_END) begin
      o_whilo = 1'b1;
      o_lo    = (w_signed && (r_reg1[31] ^ r_reg2[31])) ? (32'd0 - r_work[31:0]) : r_work[31:0];
      o_hi    = (w_signed && r_reg1[31]) ? (32'd0 - r_work[63:32]) : r_work[63:32];
    end else begin
      o_whilo = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: logic/shift results, DIV/DIVU timing and
// results, divide-by-zero, reset mid-divide, bubble insertion and downstream hold.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_stall = 1'b0;
  logic        ex_stall = 1'b0;
  logic [7:0]  aluop = 8'd0;
  logic [2:0]  alusel = 3'd0;
  logic [31:0] reg1 = 32'd0;
  logic [31:0] reg2 = 32'd0;
  logic [4:0]  wd = 5'd0;
  logic        wreg = 1'b0;
  logic [4:0]  o_wd;
  logic        o_wreg;
  logic [31:0] o_wdata;
  logic        o_whilo;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_stallreq;

  int n_checks = 0;
  int n_errors = 0;
  int nstall;

  ex_stage dut (
    .i_clk(clk), .i_rst(rst), .i_id_stall(id_stall), .i_ex_stall(ex_stall),
    .i_aluop(aluop), .i_alusel(alusel), .i_reg1(reg1), .i_reg2(reg2),
    .i_wd(wd), .i_wreg(wreg),
    .o_wd(o_wd), .o_wreg(o_wreg), .o_wdata(o_wdata), .o_whilo(o_whilo),
    .o_hi(o_hi), .o_lo(o_lo), .o_stallreq(o_stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic w);
    aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = d; wreg = w;
  endtask

  // Present one instruction for one edge, then return to NOP and move to the sampling point.
  task automatic issue(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic w);
    set_in(op, sel, a, b, d, w);
    @(posedge clk); #1;
    set_in(8'd0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (o_stallreq && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wdata", o_wdata, 32'd0);
    chk("rst_wreg", {31'd0, o_wreg}, 32'd0);
    chk("rst_wd", {27'd0, o_wd}, 32'd0);
    chk("rst_whilo", {31'd0, o_whilo}, 32'd0);
    chk("rst_hi", o_hi, 32'd0);
    chk("rst_lo", o_lo, 32'd0);
    chk("rst_stall", {31'd0, o_stallreq}, 32'd0);

    issue(8'h25, 3'b001, 32'h0000F0F0, 32'h00FF00FF, 5'd3, 1'b1);
    chk("or_wdata", o_wdata, 32'h00FFF0FF);
    chk("or_wreg", {31'd0, o_wreg}, 32'd1);
    chk("or_wd", {27'd0, o_wd}, 32'd3);
    issue(8'h26, 3'b001, 32'hFF00FF00, 32'h0F0F0F0F, 5'd4, 1'b1);
    chk("xor", o_wdata, 32'hF00FF00F);
    issue(8'h27, 3'b001, 32'hFF00FF00, 32'h0F0F0F0F, 5'd4, 1'b1);
    chk("nor", o_wdata, 32'h00F000F0);
    issue(8'h7C, 3'b010, 32'd4, 32'h80000010, 5'd2, 1'b1);
    chk("sll", o_wdata, 32'h00000100);
    issue(8'h02, 3'b010, 32'd4, 32'h80000010, 5'd2, 1'b1);
    chk("srl", o_wdata, 32'h08000001);
    issue(8'h03, 3'b010, 32'd4, 32'h80000010, 5'd2, 1'b1);
    chk("sra", o_wdata, 32'hF8000001);
    issue(8'h7C, 3'b010, 32'd31, 32'd1, 5'd2, 1'b1);
    chk("sll31", o_wdata, 32'h80000000);
    issue(8'h55, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1'b1);
    chk("unk_wdata", o_wdata, 32'd0);
    chk("unk_wreg", {31'd0, o_wreg}, 32'd1);
    chk("unk_whilo", {31'd0, o_whilo}, 32'd0);

    // DIVU 100/7, with one downstream-stalled DivEnd cycle.
    issue(8'h1B, 3'b000, 32'd100, 32'd7, 5'd5, 1'b1);
    count_stall(nstall);
    chk("divu_stall", nstall, 32'd33);
    chk("divu_whilo", {31'd0, o_whilo}, 32'd1);
    chk("divu_lo", o_lo, 32'd14);
    chk("divu_hi", o_hi, 32'd2);
    chk("divu_wreg", {31'd0, o_wreg}, 32'd0);
    ex_stall = 1'b1;
    @(negedge clk);
    chk("divend_hold_whilo", {31'd0, o_whilo}, 32'd1);
    chk("divend_hold_lo", o_lo, 32'd14);
    ex_stall = 1'b0;
    @(negedge clk);
    chk("divend_exit_whilo", {31'd0, o_whilo}, 32'd0);
    chk("divend_exit_lo", o_lo, 32'd0);

    issue(8'h1A, 3'b000, 32'hFFFFFFF9, 32'd2, 5'd5, 1'b1);
    count_stall(nstall);
    chk("div_stall", nstall, 32'd33);
    chk("div_lo", o_lo, 32'hFFFFFFFD);
    chk("div_hi", o_hi, 32'hFFFFFFFF);
    chk("div_whilo", {31'd0, o_whilo}, 32'd1);
    @(negedge clk);

    issue(8'h1A, 3'b000, 32'd5, 32'd0, 5'd5, 1'b1);
    count_stall(nstall);
    chk("dz_stall", nstall, 32'd2);
    chk("dz_whilo", {31'd0, o_whilo}, 32'd1);
    chk("dz_hi", o_hi, 32'd0);
    chk("dz_lo", o_lo, 32'd0);
    @(negedge clk);

    // Reset in the middle of a divide.
    issue(8'h1B, 3'b000, 32'd100, 32'd7, 5'd5, 1'b1);
    repeat (10) @(negedge clk);
    chk("mid_stall_before", {31'd0, o_stallreq}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_stall", {31'd0, o_stallreq}, 32'd0);
    chk("mid_rst_whilo", {31'd0, o_whilo}, 32'd0);
    chk("mid_rst_hi", o_hi, 32'd0);
    chk("mid_rst_lo", o_lo, 32'd0);
    chk("mid_rst_wd", {27'd0, o_wd}, 32'd0);
    repeat (35) @(negedge clk);
    chk("mid_rst_no_write", {31'd0, o_whilo}, 32'd0);
    issue(8'h25, 3'b001, 32'h0000F0F0, 32'h00FF00FF, 5'd3, 1'b1);
    chk("post_rst_or", o_wdata, 32'h00FFF0FF);
    chk("post_rst_wreg", {31'd0, o_wreg}, 32'd1);

    // Bubble from a decode stall.
    set_in(8'h25, 3'b001, 32'h1, 32'h2, 5'd6, 1'b1);
    id_stall = 1'b1;
    @(posedge clk); #1;
    id_stall = 1'b0;
    set_in(8'd0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("bubble_wreg", {31'd0, o_wreg}, 32'd0);
    chk("bubble_wdata", o_wdata, 32'd0);

    // Downstream hold across an AND, including a simultaneous decode stall.
    issue(8'h24, 3'b001, 32'hFF00FF00, 32'h0F0F0F0F, 5'd7, 1'b1);
    chk("and", o_wdata, 32'h0F000F00);
    set_in(8'h26, 3'b001, 32'h12345678, 32'hFFFFFFFF, 5'd8, 1'b1);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_stall = (i == 1);
      @(negedge clk);
      chk("hold_wdata", o_wdata, 32'h0F000F00);
      chk("hold_wd", {27'd0, o_wd}, 32'd7);
      chk("hold_wreg", {31'd0, o_wreg}, 32'd1);
    end
    id_stall = 1'b0;
    ex_stall = 1'b0;
    @(negedge clk);
    chk("release_xor", o_wdata, 32'hEDCBA987);
    chk("release_wd", {27'd0, o_wd}, 32'd8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
